// File: rtl/bli201v32itl_core_exu_bjp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bli201v32itl_core_exu_bjp_pkg
// Brief   : Shared constants and FSM encoding for the branch/jump unit.
// Revision: 1.0
// ============================================================================
package bli201v32itl_core_exu_bjp_pkg;

   localparam int c_XLEN = 32;

   localparam logic [2:0] c_BEQ  = 3'b000;
   localparam logic [2:0] c_BNE  = 3'b001;
   localparam logic [2:0] c_BLT  = 3'b100;
   localparam logic [2:0] c_BGE  = 3'b101;
   localparam logic [2:0] c_BLTU = 3'b110;
   localparam logic [2:0] c_BGEU = 3'b111;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } bjp_state_t;

endpackage : bli201v32itl_core_exu_bjp_pkg
`default_nettype wire

// File: rtl/bli201v32itl_core_exu_bjp_cond.sv
`default_nettype none
// ============================================================================
// Module  : bli201v32itl_core_exu_bjp_cond
// Brief   : funct3 + comparator flags -> branch condition / illegal decode.
// Revision: 1.0
// ============================================================================
module bli201v32itl_core_exu_bjp_cond
   import bli201v32itl_core_exu_bjp_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_eq,
   input  logic       i_lt,
   output logic       o_cond,
   output logic       o_illegal
);

   // Signed/unsigned share one lt flag; the bru is steered by funct3[1].
   always_comb begin
      o_cond    = 1'b0;
      o_illegal = 1'b0;
      case (i_funct3)
         c_BEQ:          o_cond = i_eq;
         c_BNE:          o_cond = ~i_eq;
         c_BLT, c_BLTU:  o_cond = i_lt;
         c_BGE, c_BGEU:  o_cond = ~i_lt;
         default:        o_illegal = 1'b1;
      endcase
   end

endmodule : bli201v32itl_core_exu_bjp_cond
`default_nettype wire

// File: rtl/bli201v32itl_core_exu_bjp.sv
`default_nettype none
// ============================================================================
// Module  : bli201v32itl_core_exu_bjp
// Brief   : Branch/jump resolution, registered IFU redirect, perf counters.
// Revision: 1.0
// ============================================================================
module bli201v32itl_core_exu_bjp
   import bli201v32itl_core_exu_bjp_pkg::*;
#(
   parameter int              CNT_W  = 32,
   parameter logic [31:0]     RST_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               bjp_i_valid,
   output logic               bjp_o_ready,
   input  logic [c_XLEN-1:0]  bjp_i_pc,
   input  logic [c_XLEN-1:0]  bjp_i_imm,
   input  logic [c_XLEN-1:0]  bjp_i_rs1,
   input  logic [2:0]         bjp_i_funct3,
   input  logic               bjp_i_is_br,
   input  logic               bjp_i_is_jal,
   input  logic               bjp_i_is_jalr,
   output logic               bjp_o_br_un,
   input  logic               bjp_i_br_eq,
   input  logic               bjp_i_br_lt,
   output logic               bjp_o_redir_valid,
   input  logic               bjp_i_redir_ready,
   output logic [c_XLEN-1:0]  bjp_o_redir_pc,
   output logic               bjp_o_flush,
   output logic               bjp_o_link_valid,
   output logic [c_XLEN-1:0]  bjp_o_link_data,
   output logic               bjp_o_misalign,
   output logic               bjp_o_illegal,
   output logic [CNT_W-1:0]   bjp_o_br_cnt,
   output logic [CNT_W-1:0]   bjp_o_taken_cnt
);

   bjp_state_t           r_state;
   logic                 r_redir_valid;
   logic [c_XLEN-1:0]    r_redir_pc;
   logic                 r_flush;
   logic                 r_link_valid;
   logic [c_XLEN-1:0]    r_link_data;
   logic                 r_misalign;
   logic                 r_illegal;
   logic [CNT_W-1:0]     r_br_cnt;
   logic [CNT_W-1:0]     r_taken_cnt;

   logic                 w_accept;
   logic                 w_jalr;
   logic                 w_jal;
   logic                 w_br;
   logic                 w_cond;
   logic                 w_cond_illegal;
   logic                 w_br_legal;
   logic                 w_taken;
   logic [c_XLEN-1:0]    w_target;
   logic                 w_misalign;

   bli201v32itl_core_exu_bjp_cond u_cond (
      .i_funct3  (bjp_i_funct3),
      .i_eq      (bjp_i_br_eq),
      .i_lt      (bjp_i_br_lt),
      .o_cond    (w_cond),
      .o_illegal (w_cond_illegal)
   );

   // One-hot type after priority resolution: jalr > jal > br.
   assign w_jalr     = bjp_i_is_jalr;
   assign w_jal      = bjp_i_is_jal & ~bjp_i_is_jalr;
   assign w_br       = bjp_i_is_br & ~bjp_i_is_jal & ~bjp_i_is_jalr;
   assign w_br_legal = w_br & ~w_cond_illegal;

   assign w_accept   = bjp_i_valid & (r_state == IDLE);
   assign w_taken    = w_jal | w_jalr | (w_br_legal & w_cond);
   assign w_target   = w_jalr ? ((bjp_i_rs1 + bjp_i_imm) & ~32'h1)
                              : (bjp_i_pc + bjp_i_imm);
   assign w_misalign = w_taken & (w_target[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_redir_valid <= 1'b0;
         r_redir_pc    <= RST_PC;
         r_flush       <= 1'b0;
         r_link_valid  <= 1'b0;
         r_link_data   <= '0;
         r_misalign    <= 1'b0;
         r_illegal     <= 1'b0;
         r_br_cnt      <= '0;
         r_taken_cnt   <= '0;
      end else begin
         r_flush      <= 1'b0;
         r_link_valid <= 1'b0;
         r_misalign   <= 1'b0;
         r_illegal    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_jal | w_jalr) begin
                     r_link_valid <= 1'b1;
                     r_link_data  <= bjp_i_pc + 32'd4;
                  end
                  if (w_br & w_cond_illegal) begin
                     r_illegal <= 1'b1;
                  end
                  if (w_br_legal) begin
                     if (r_br_cnt != {CNT_W{1'b1}}) begin
                        r_br_cnt <= r_br_cnt + 1'b1;
                     end
                     if (w_cond && (r_taken_cnt != {CNT_W{1'b1}})) begin
                        r_taken_cnt <= r_taken_cnt + 1'b1;
                     end
                  end
                  if (w_taken) begin
                     r_redir_pc <= w_target;
                     if (w_misalign) begin
                        r_misalign <= 1'b1;
                     end else begin
                        r_redir_valid <= 1'b1;
                        r_flush       <= 1'b1;
                        r_state       <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (bjp_i_redir_ready) begin
                  r_redir_valid <= 1'b0;
                  r_state       <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bjp_o_ready       = (r_state == IDLE);
   assign bjp_o_br_un       = bjp_i_funct3[1];
   assign bjp_o_redir_valid = r_redir_valid;
   assign bjp_o_redir_pc    = r_redir_pc;
   assign bjp_o_flush       = r_flush;
   assign bjp_o_link_valid  = r_link_valid;
   assign bjp_o_link_data   = r_link_data;
   assign bjp_o_misalign    = r_misalign;
   assign bjp_o_illegal     = r_illegal;
   assign bjp_o_br_cnt      = r_br_cnt;
   assign bjp_o_taken_cnt   = r_taken_cnt;

endmodule : bli201v32itl_core_exu_bjp
`default_nettype wire

// File: tb/tb_bli201v32itl_core_exu_bjp.sv
`default_nettype none
// ============================================================================
// Module  : tb_bli201v32itl_core_exu_bjp
// Brief   : Directed self-checking bench for the branch/jump unit.
// Revision: 1.0
// ============================================================================
module tb_bli201v32itl_core_exu_bjp;

   localparam int          CNT_W  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0080;

   logic              clk;
   logic              rst_n;
   logic              bjp_i_valid;
   logic              bjp_o_ready;
   logic [31:0]       bjp_i_pc;
   logic [31:0]       bjp_i_imm;
   logic [31:0]       bjp_i_rs1;
   logic [2:0]        bjp_i_funct3;
   logic              bjp_i_is_br;
   logic              bjp_i_is_jal;
   logic              bjp_i_is_jalr;
   logic              bjp_o_br_un;
   logic              bjp_i_br_eq;
   logic              bjp_i_br_lt;
   logic              bjp_o_redir_valid;
   logic              bjp_i_redir_ready;
   logic [31:0]       bjp_o_redir_pc;
   logic              bjp_o_flush;
   logic              bjp_o_link_valid;
   logic [31:0]       bjp_o_link_data;
   logic              bjp_o_misalign;
   logic              bjp_o_illegal;
   logic [CNT_W-1:0]  bjp_o_br_cnt;
   logic [CNT_W-1:0]  bjp_o_taken_cnt;

   int total;
   int bad;

   bli201v32itl_core_exu_bjp #(
      .CNT_W  (CNT_W),
      .RST_PC (RST_PC)
   ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bjp_i_valid       (bjp_i_valid),
      .bjp_o_ready       (bjp_o_ready),
      .bjp_i_pc          (bjp_i_pc),
      .bjp_i_imm         (bjp_i_imm),
      .bjp_i_rs1         (bjp_i_rs1),
      .bjp_i_funct3      (bjp_i_funct3),
      .bjp_i_is_br       (bjp_i_is_br),
      .bjp_i_is_jal      (bjp_i_is_jal),
      .bjp_i_is_jalr     (bjp_i_is_jalr),
      .bjp_o_br_un       (bjp_o_br_un),
      .bjp_i_br_eq       (bjp_i_br_eq),
      .bjp_i_br_lt       (bjp_i_br_lt),
      .bjp_o_redir_valid (bjp_o_redir_valid),
      .bjp_i_redir_ready (bjp_i_redir_ready),
      .bjp_o_redir_pc    (bjp_o_redir_pc),
      .bjp_o_flush       (bjp_o_flush),
      .bjp_o_link_valid  (bjp_o_link_valid),
      .bjp_o_link_data   (bjp_o_link_data),
      .bjp_o_misalign    (bjp_o_misalign),
      .bjp_o_illegal     (bjp_o_illegal),
      .bjp_o_br_cnt      (bjp_o_br_cnt),
      .bjp_o_taken_cnt   (bjp_o_taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request from the negedge, hold it across one posedge, then drop it.
   task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [2:0] f3, input logic br, input logic jal, input logic jalr,
                        input logic eq, input logic lt);
      @(negedge clk);
      bjp_i_valid   = 1'b1;
      bjp_i_pc      = pc;
      bjp_i_imm     = imm;
      bjp_i_rs1     = rs1;
      bjp_i_funct3  = f3;
      bjp_i_is_br   = br;
      bjp_i_is_jal  = jal;
      bjp_i_is_jalr = jalr;
      bjp_i_br_eq   = eq;
      bjp_i_br_lt   = lt;
      step();
      bjp_i_valid   = 1'b0;
      bjp_i_is_br   = 1'b0;
      bjp_i_is_jal  = 1'b0;
      bjp_i_is_jalr = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bjp_i_valid = 1'b0; bjp_i_pc = '0; bjp_i_imm = '0; bjp_i_rs1 = '0;
      bjp_i_funct3 = 3'b000; bjp_i_is_br = 1'b0; bjp_i_is_jal = 1'b0; bjp_i_is_jalr = 1'b0;
      bjp_i_br_eq = 1'b0; bjp_i_br_lt = 1'b0; bjp_i_redir_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bjp_o_ready), 32'd1);
      chk("rst_rvalid", 32'(bjp_o_redir_valid), 32'd0);
      chk("rst_rpc", bjp_o_redir_pc, RST_PC);
      chk("rst_flush", 32'(bjp_o_flush), 32'd0);
      chk("rst_brcnt", 32'(bjp_o_br_cnt), 32'd0);
      chk("rst_tkcnt", 32'(bjp_o_taken_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // BEQ taken, redirect accepted immediately
      issue(32'h100, 32'h20, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("beq_rvalid", 32'(bjp_o_redir_valid), 32'd1);
      chk("beq_rpc", bjp_o_redir_pc, 32'h120);
      chk("beq_flush", 32'(bjp_o_flush), 32'd1);
      chk("beq_ready", 32'(bjp_o_ready), 32'd0);
      chk("beq_brcnt", 32'(bjp_o_br_cnt), 32'd1);
      chk("beq_tkcnt", 32'(bjp_o_taken_cnt), 32'd1);
      step();
      chk("beq_rvalid2", 32'(bjp_o_redir_valid), 32'd0);
      chk("beq_flush2", 32'(bjp_o_flush), 32'd0);
      chk("beq_ready2", 32'(bjp_o_ready), 32'd1);

      // BLTU not taken; br_un follows funct3[1] combinationally
      @(negedge clk);
      bjp_i_funct3 = 3'b110;
      #1;
      chk("bltu_brun", 32'(bjp_o_br_un), 32'd1);
      issue(32'h140, 32'h40, 32'h0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bltu_rvalid", 32'(bjp_o_redir_valid), 32'd0);
      chk("bltu_flush", 32'(bjp_o_flush), 32'd0);
      chk("bltu_brcnt", 32'(bjp_o_br_cnt), 32'd2);
      chk("bltu_tkcnt", 32'(bjp_o_taken_cnt), 32'd1);
      bjp_i_funct3 = 3'b000;
      #1;
      chk("beq_brun", 32'(bjp_o_br_un), 32'd0);

      // JALR 0x1003+4 -> 0x1006: bit0 cleared, bit1 set so it is misaligned
      issue(32'h200, 32'h4, 32'h1003, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("jalr1_rpc", bjp_o_redir_pc, 32'h1006);
      chk("jalr1_mis", 32'(bjp_o_misalign), 32'd1);
      chk("jalr1_rvalid", 32'(bjp_o_redir_valid), 32'd0);
      chk("jalr1_lvalid", 32'(bjp_o_link_valid), 32'd1);
      chk("jalr1_ldata", bjp_o_link_data, 32'h204);
      issue(32'h210, 32'h1, 32'h1001, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("jalr2_rpc", bjp_o_redir_pc, 32'h1002);
      chk("jalr2_mis", 32'(bjp_o_misalign), 32'd1);
      chk("jalr2_rvalid", 32'(bjp_o_redir_valid), 32'd0);
      chk("jalr2_flush", 32'(bjp_o_flush), 32'd0);
      chk("jalr2_lvalid", 32'(bjp_o_link_valid), 32'd1);
      chk("jalr2_ldata", bjp_o_link_data, 32'h214);
      chk("jalr2_ready", 32'(bjp_o_ready), 32'd1);
      step();
      chk("jalr2_mis_off", 32'(bjp_o_misalign), 32'd0);
      chk("jalr2_lv_off", 32'(bjp_o_link_valid), 32'd0);
      chk("jalr_brcnt", 32'(bjp_o_br_cnt), 32'd2);

      // JAL with IFU back-pressure; a new request during HOLD is ignored
      bjp_i_redir_ready = 1'b0;
      issue(32'h300, 32'h40, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hold1_rvalid", 32'(bjp_o_redir_valid), 32'd1);
      chk("hold1_rpc", bjp_o_redir_pc, 32'h340);
      chk("hold1_flush", 32'(bjp_o_flush), 32'd1);
      chk("hold1_ready", 32'(bjp_o_ready), 32'd0);
      issue(32'h500, 32'h8, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("hold2_rvalid", 32'(bjp_o_redir_valid), 32'd1);
      chk("hold2_rpc", bjp_o_redir_pc, 32'h340);
      chk("hold2_flush", 32'(bjp_o_flush), 32'd0);
      chk("hold2_brcnt", 32'(bjp_o_br_cnt), 32'd2);
      step();
      chk("hold3_rvalid", 32'(bjp_o_redir_valid), 32'd1);
      chk("hold3_rpc", bjp_o_redir_pc, 32'h340);
      chk("hold3_ready", 32'(bjp_o_ready), 32'd0);
      @(negedge clk);
      bjp_i_redir_ready = 1'b1;
      step();
      chk("hold_done_rvalid", 32'(bjp_o_redir_valid), 32'd0);
      chk("hold_done_ready", 32'(bjp_o_ready), 32'd1);

      // Reserved funct3 on a branch
      issue(32'h600, 32'h10, 32'h0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("ill_pulse", 32'(bjp_o_illegal), 32'd1);
      chk("ill_rvalid", 32'(bjp_o_redir_valid), 32'd0);
      chk("ill_brcnt", 32'(bjp_o_br_cnt), 32'd2);
      chk("ill_tkcnt", 32'(bjp_o_taken_cnt), 32'd1);
      step();
      chk("ill_off", 32'(bjp_o_illegal), 32'd0);

      // JALR wins over an illegal branch flag set alongside it
      issue(32'h700, 32'h10, 32'h2000, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("prio_ill", 32'(bjp_o_illegal), 32'd0);
      chk("prio_rpc", bjp_o_redir_pc, 32'h2010);
      chk("prio_rvalid", 32'(bjp_o_redir_valid), 32'd1);
      chk("prio_brcnt", 32'(bjp_o_br_cnt), 32'd2);
      step();

      // Address wrap on target and link
      issue(32'hFFFF_FFFC, 32'h8, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("wrap_rpc", bjp_o_redir_pc, 32'h4);
      chk("wrap_ldata", bjp_o_link_data, 32'h0);
      chk("wrap_rvalid", 32'(bjp_o_redir_valid), 32'd1);
      step();

      // Asynchronous reset while a redirect is pending
      bjp_i_redir_ready = 1'b0;
      issue(32'h800, 32'h20, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("arst_pre_rvalid", 32'(bjp_o_redir_valid), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_rvalid", 32'(bjp_o_redir_valid), 32'd0);
      chk("arst_rpc", bjp_o_redir_pc, RST_PC);
      chk("arst_brcnt", 32'(bjp_o_br_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bjp_i_redir_ready = 1'b1;
      #1;
      chk("arst_ready", 32'(bjp_o_ready), 32'd1);

      // 17 taken branches drive the narrow counters into saturation
      for (int i = 0; i < 17; i++) begin
         issue(32'h1000, 32'h8, 32'h0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      chk("sat_brcnt", 32'(bjp_o_br_cnt), 32'hF);
      chk("sat_tkcnt", 32'(bjp_o_taken_cnt), 32'hF);
      issue(32'h1000, 32'h8, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_nt_brcnt", 32'(bjp_o_br_cnt), 32'hF);
      chk("sat_nt_tkcnt", 32'(bjp_o_taken_cnt), 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_bli201v32itl_core_exu_bjp
`default_nettype wire
